bool_lut_eval_multi: RTL and testbench

//  Programmable multi-channel Boolean function evaluator; generalises the fixed 2-input K-map combinational problems.

---
 rtl/bool_lut_pkg.sv | 21 ++
 rtl/bool_lut_bank.sv | 57 +++++
 rtl/bool_lut_eval_multi.sv | 158 +++++++++++++++
 tb/tb_bool_lut_eval_multi.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bool_lut_pkg.sv
// Shared types and helpers for the programmable Boolean LUT evaluator.
package bool_lut_pkg;

  // Default variable count; modules carry their own NVARS parameter.
  localparam int LUT_NVARS = 2;

  // One truth table for the default variable count: bit k = f(minterm k).
  typedef logic [2**LUT_NVARS-1:0] tt_t;

  // Top-level controller states.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // Channel-select width; never zero, even for a single channel.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bool_lut_bank.sv
// Truth-table register file: one synchronous write port, two combinational read ports.
module bool_lut_bank
  import bool_lut_pkg::*;
#(
  parameter int                 NVARS      = 2,
  parameter int                 NCHAN      = 4,
  parameter logic [2**NVARS-1:0] DEFAULT_TT = '0,
  parameter int                 CW         = chan_w(NCHAN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [CW-1:0]        wchan,
  input  logic [2**NVARS-1:0]  wdata,
  input  logic [CW-1:0]        rchan_a,
  output logic [2**NVARS-1:0]  rdata_a,
  input  logic [CW-1:0]        rchan_b,
  output logic [2**NVARS-1:0]  rdata_b
);

  localparam int TTW = 2**NVARS;

  logic [TTW-1:0]   tt_q [NCHAN];
  logic [TTW-1:0]   tt_d [NCHAN];
  logic [NCHAN-1:0] wsel;

  // Per-channel write decode; a channel number with no matching entry writes nothing.
  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_wsel
    assign wsel[gi] = we && (wchan == CW'(gi));
  end

  // Next-state tables: replace only the selected channel.
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      tt_d[i] = wsel[i] ? wdata : tt_q[i];
    end
  end

  // Table storage; active-low synchronous reset restores the default table everywhere.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (!reset) tt_q[i] <= DEFAULT_TT;
      else        tt_q[i] <= tt_d[i];
    end
  end

  // Read ports see the current (pre-write) contents, giving read-before-write.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (rchan_a == CW'(i)) rdata_a = tt_q[i];
      if (rchan_b == CW'(i)) rdata_b = tt_q[i];
    end
  end

endmodule

// File: rtl/bool_lut_eval_multi.sv
// Multi-channel programmable Boolean evaluator with a registered,
// back-pressured output stage and a truth-table sweep mode.
module bool_lut_eval_multi
  import bool_lut_pkg::*;
#(
  parameter int                  NVARS      = 2,
  parameter int                  NCHAN      = 4,
  parameter logic [2**NVARS-1:0] DEFAULT_TT = '0,
  parameter int                  CW         = chan_w(NCHAN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_val,
  output logic                cfg_rdy,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [2**NVARS-1:0] cfg_tt,
  input  logic                sweep_val,
  output logic                sweep_rdy,
  input  logic [CW-1:0]       sweep_chan,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [CW-1:0]       in_chan,
  input  logic [NVARS-1:0]    in_vars,
  output logic                out_val,
  input  logic                out_rdy,
  output logic                out_f,
  output logic [CW-1:0]       out_chan,
  output logic [NVARS-1:0]    out_idx,
  output logic                out_sweep,
  output logic                out_last
);

  localparam int            TTW      = 2**NVARS;
  localparam int            IW       = NVARS + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TTW - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       sw_chan_q, sw_chan_d;
  logic [IW-1:0]       sw_idx_q, sw_idx_d;
  logic                out_val_q, out_val_d;
  logic                out_f_q, out_f_d;
  logic [CW-1:0]       out_chan_q, out_chan_d;
  logic [NVARS-1:0]    out_idx_q, out_idx_d;
  logic                out_sweep_q, out_sweep_d;
  logic                out_last_q, out_last_d;

  logic                advance;
  logic                in_acc;
  logic                cfg_acc;
  logic                sweep_acc;
  logic [TTW-1:0]      eval_tt;
  logic [TTW-1:0]      sweep_tt;

  bool_lut_bank #(
    .NVARS      (NVARS),
    .NCHAN      (NCHAN),
    .DEFAULT_TT (DEFAULT_TT),
    .CW         (CW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (cfg_acc),
    .wchan   (cfg_chan),
    .wdata   (cfg_tt),
    .rchan_a (in_chan),
    .rdata_a (eval_tt),
    .rchan_b (sw_chan_q),
    .rdata_b (sweep_tt)
  );

  // Handshake decode; out_rdy feeds in_rdy combinationally so a drain and a new accept share a cycle.
  always_comb begin
    advance   = !out_val_q || out_rdy;
    cfg_rdy   = (state_q == IDLE);
    sweep_rdy = (state_q == IDLE);
    in_rdy    = (state_q == IDLE) && advance;
    cfg_acc   = cfg_val && cfg_rdy;
    sweep_acc = sweep_val && sweep_rdy;
    in_acc    = in_val && in_rdy;
  end

  // Next-state: FSM, sweep counter and the single output register.
  always_comb begin
    state_d     = state_q;
    sw_chan_d   = sw_chan_q;
    sw_idx_d    = sw_idx_q;
    out_val_d   = out_val_q;
    out_f_d     = out_f_q;
    out_chan_d  = out_chan_q;
    out_idx_d   = out_idx_q;
    out_sweep_d = out_sweep_q;
    out_last_d  = out_last_q;

    if (state_q == IDLE) begin
      // Sweep start does not block an eval presented in the same cycle.
      if (sweep_acc) begin
        state_d   = SWEEP;
        sw_chan_d = sweep_chan;
        sw_idx_d  = '0;
      end
      if (advance) begin
        out_val_d = in_acc;
        if (in_acc) begin
          out_f_d     = eval_tt[in_vars];
          out_chan_d  = in_chan;
          out_idx_d   = in_vars;
          out_sweep_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
    end else begin
      // One minterm per advance; stalls hold idx so nothing is skipped or repeated.
      if (advance) begin
        out_val_d   = 1'b1;
        out_f_d     = sweep_tt[sw_idx_q[NVARS-1:0]];
        out_chan_d  = sw_chan_q;
        out_idx_d   = sw_idx_q[NVARS-1:0];
        out_sweep_d = 1'b1;
        out_last_d  = (sw_idx_q == LAST_IDX);
        sw_idx_d    = sw_idx_q + IW'(1);
        if (sw_idx_q == LAST_IDX) state_d = IDLE;
      end
    end
  end

  // State registers with active-low synchronous reset; any held result is discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sw_chan_q   <= '0;
      sw_idx_q    <= '0;
      out_val_q   <= 1'b0;
      out_f_q     <= 1'b0;
      out_chan_q  <= '0;
      out_idx_q   <= '0;
      out_sweep_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_chan_q   <= sw_chan_d;
      sw_idx_q    <= sw_idx_d;
      out_val_q   <= out_val_d;
      out_f_q     <= out_f_d;
      out_chan_q  <= out_chan_d;
      out_idx_q   <= out_idx_d;
      out_sweep_q <= out_sweep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_val   = out_val_q;
  assign out_f     = out_f_q;
  assign out_chan  = out_chan_q;
  assign out_idx   = out_idx_q;
  assign out_sweep = out_sweep_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bool_lut_eval_multi.sv
// Directed self-checking bench for bool_lut_eval_multi (NVARS=2, NCHAN=4, default table 0).
module tb_bool_lut_eval_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_val;
  logic       cfg_rdy;
  logic [1:0] cfg_chan;
  logic [3:0] cfg_tt;
  logic       sweep_val;
  logic       sweep_rdy;
  logic [1:0] sweep_chan;
  logic       in_val;
  logic       in_rdy;
  logic [1:0] in_chan;
  logic [1:0] in_vars;
  logic       out_val;
  logic       out_rdy;
  logic       out_f;
  logic [1:0] out_chan;
  logic [1:0] out_idx;
  logic       out_sweep;
  logic       out_last;

  int n_assert = 0;
  int n_fail   = 0;

  bool_lut_eval_multi #(
    .NVARS      (2),
    .NCHAN      (4),
    .DEFAULT_TT (4'b0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_val    (cfg_val),
    .cfg_rdy    (cfg_rdy),
    .cfg_chan   (cfg_chan),
    .cfg_tt     (cfg_tt),
    .sweep_val  (sweep_val),
    .sweep_rdy  (sweep_rdy),
    .sweep_chan (sweep_chan),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_chan    (in_chan),
    .in_vars    (in_vars),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_f      (out_f),
    .out_chan   (out_chan),
    .out_idx    (out_idx),
    .out_sweep  (out_sweep),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_tt;

    reset = 1'b0; cfg_val = 1'b0; cfg_chan = '0; cfg_tt = '0;
    sweep_val = 1'b0; sweep_chan = '0; in_val = 1'b0; in_chan = '0;
    in_vars = '0; out_rdy = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_out_val", out_val, 0);
    chk("rst_out_f", out_f, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_sweep", out_sweep, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sweep_rdy", sweep_rdy, 1);
    reset = 1'b1;
    tick();
    $display("reset done");

    // 1: default table, one-cycle latency
    for (int v = 0; v < 4; v++) begin
      in_val = 1'b1; in_chan = 2'd0; in_vars = v[1:0];
      tick();
      chk("t1_val", out_val, 1);
      chk("t1_f", out_f, 0);
      chk("t1_idx", out_idx, v);
      $display("t1 eval chan0 vars=%0d f=%0b", v, out_f);
    end
    in_val = 1'b0;
    tick();
    chk("t1_drain", out_val, 0);

    // 2: XOR on chan1, back to back
    cfg_val = 1'b1; cfg_chan = 2'd1; cfg_tt = 4'b0110;
    tick();
    cfg_val = 1'b0;
    exp_tt = 4'b0110;
    for (int v = 0; v < 4; v++) begin
      in_val = 1'b1; in_chan = 2'd1; in_vars = v[1:0];
      tick();
      chk("t2_val", out_val, 1);
      chk("t2_f", out_f, exp_tt[v]);
      chk("t2_chan", out_chan, 1);
      $display("t2 eval chan1 vars=%0d f=%0b", v, out_f);
    end
    in_val = 1'b0;
    tick();

    // 3: same-cycle cfg and eval reads the old table
    cfg_val = 1'b1; cfg_chan = 2'd2; cfg_tt = 4'b1000;
    in_val = 1'b1; in_chan = 2'd2; in_vars = 2'd3;
    tick();
    cfg_val = 1'b0;
    chk("t3_old_f", out_f, 0);
    $display("t3 same-cycle eval f=%0b", out_f);
    tick();
    chk("t3_new_f", out_f, 1);
    $display("t3 next eval f=%0b", out_f);
    in_val = 1'b0;
    tick();

    // 4: sweep chan1 with out_rdy toggling
    sweep_val = 1'b1; sweep_chan = 2'd1;
    tick();
    sweep_val = 1'b0;
    chk("t4_sweep_rdy", sweep_rdy, 0);
    chk("t4_cfg_rdy", cfg_rdy, 0);
    chk("t4_in_rdy", in_rdy, 0);
    for (int k = 0; k < 4; k++) begin
      out_rdy = 1'b1;
      tick();
      chk("t4_val", out_val, 1);
      chk("t4_idx", out_idx, k);
      chk("t4_f", out_f, exp_tt[k]);
      chk("t4_last", out_last, (k == 3) ? 1 : 0);
      chk("t4_sweep", out_sweep, 1);
      if (k < 3) chk("t4_cfg_rdy_in", cfg_rdy, 0);
      $display("t4 sweep idx=%0d f=%0b last=%0b", out_idx, out_f, out_last);
      out_rdy = 1'b0;
      #1;
      chk("t4_in_rdy_stall", in_rdy, 0);
      tick();
      chk("t4_hold_val", out_val, 1);
      chk("t4_hold_idx", out_idx, k);
      chk("t4_hold_last", out_last, (k == 3) ? 1 : 0);
    end
    out_rdy = 1'b1;
    tick();
    chk("t4_drain", out_val, 0);
    chk("t4_back_idle", sweep_rdy, 1);

    // 5: reset mid-sweep
    sweep_val = 1'b1; sweep_chan = 2'd1;
    tick();
    sweep_val = 1'b0;
    tick();
    chk("t5_idx0", out_idx, 0);
    tick();
    chk("t5_idx1", out_idx, 1);
    reset = 1'b0;
    tick();
    chk("t5_val", out_val, 0);
    chk("t5_sweep_rdy", sweep_rdy, 1);
    chk("t5_out_sweep", out_sweep, 0);
    reset = 1'b1;
    tick();
    in_val = 1'b1; in_chan = 2'd1; in_vars = 2'd1;
    tick();
    chk("t5_chan1_default", out_f, 0);
    in_chan = 2'd2; in_vars = 2'd3;
    tick();
    chk("t5_chan2_default", out_f, 0);
    $display("t5 reset mid-sweep, tables default");
    in_val = 1'b0;
    tick();

    // 6: back-pressure and same-cycle drain/accept
    cfg_val = 1'b1; cfg_chan = 2'd0; cfg_tt = 4'b0101;
    tick();
    cfg_val = 1'b0;
    out_rdy = 1'b0;
    in_val = 1'b1; in_chan = 2'd0; in_vars = 2'd0;
    tick();
    chk("t6_val", out_val, 1);
    chk("t6_f", out_f, 1);
    in_vars = 2'd2;
    #1;
    chk("t6_in_rdy_blocked", in_rdy, 0);
    tick();
    chk("t6_hold_idx", out_idx, 0);
    tick();
    chk("t6_hold_idx2", out_idx, 0);
    out_rdy = 1'b1; in_vars = 2'd3;
    #1;
    chk("t6_in_rdy_open", in_rdy, 1);
    tick();
    chk("t6_new_val", out_val, 1);
    chk("t6_new_idx", out_idx, 3);
    chk("t6_new_f", out_f, 0);
    $display("t6 drained and accepted idx=%0d f=%0b", out_idx, out_f);
    in_val = 1'b0;
    tick();
    chk("t6_drain", out_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
